// File: rtl/microtile_capture_pkg.sv
// Shared types and defaults for the microtile capture block.
// Build option: CAPTURE_DEGLITCH_EN (see microtile_capture.sv).
package microtile_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Qualifier modes; code 3 is reserved and behaves like MODE_CHANGE.
    localparam logic [1:0] MODE_CHANGE = 2'd0;
    localparam logic [1:0] MODE_MATCH  = 2'd1;
    localparam logic [1:0] MODE_ALL    = 2'd2;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_TS_W   = 8;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO holding {timestamp, sample} records.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   i_push, i_data   write request and record
//   i_pop            read request (ignored when empty)
//   i_clear          flush pointers/count/overflow; beats push and pop
//   o_valid, o_data  non-empty flag and head record (zero when empty)
//   o_count, o_full  occupancy and full flag
//   o_overflow       sticky: a push was dropped because the FIFO was full
module capture_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output logic                       o_valid,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && !w_push) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !i_clear && w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_valid    = !w_empty;
    assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/microtile_capture.sv
// Registers a combinational microtile's output and logs qualifying samples
// with a cycle timestamp into a FIFO drained through a valid/ready port.
// Build option: CAPTURE_DEGLITCH_EN -- tile_out must be stable for two
// enabled cycles before it reaches the sample register (+1 cycle latency).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ena                   freezes sampling and timestamp when low
//   tile_out              tile uo_out
//   arm, stop             one-cycle control pulses
//   mode, pattern, mask   qualifier selection (change / match / all)
//   clear                 flush FIFO and overflow
//   rd_valid/ready/data   read port, data = {timestamp, sample}
//   count, full, overflow FIFO status
//   state                 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
module microtile_capture
    import microtile_capture_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TS_W   = DEF_TS_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [DATA_W-1:0]         tile_out,
    input  logic                      arm,
    input  logic                      stop,
    input  logic [1:0]                mode,
    input  logic [DATA_W-1:0]         pattern,
    input  logic [DATA_W-1:0]         mask,
    input  logic                      clear,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [TS_W+DATA_W-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      overflow,
    output logic [1:0]                state
);
    logic [DATA_W-1:0] r_cur;
    logic [DATA_W-1:0] r_prev;
    logic [TS_W-1:0]   r_ts;
    state_t            r_state;

    state_t            w_state_nxt;
    logic [TS_W-1:0]   w_ts_nxt;
    logic              w_push;
    logic              w_qual;

    // ---------------- sample stage ----------------
`ifdef CAPTURE_DEGLITCH_EN
    logic [DATA_W-1:0] r_stab;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stab <= '0;
            r_cur  <= '0;
            r_prev <= '0;
        end else if (ena) begin
            r_stab <= tile_out;
            r_prev <= r_cur;
            // Accept only a value already seen on the previous enabled cycle.
            if (tile_out == r_stab) r_cur <= tile_out;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cur  <= '0;
            r_prev <= '0;
        end else if (ena) begin
            r_prev <= r_cur;
            r_cur  <= tile_out;
        end
    end
`endif

    // ---------------- qualifier ----------------
    always_comb begin
        w_qual = 1'b0;
        case (mode)
            MODE_MATCH: w_qual = ((r_cur & mask) == (pattern & mask));
            MODE_ALL:   w_qual = 1'b1;
            default:    w_qual = (r_cur != r_prev);
        endcase
    end

    // ---------------- state machine / timestamp ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ts    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ts    <= w_ts_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ts_nxt    = r_ts;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ts_nxt = '0;
                if (arm) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                w_ts_nxt = '0;
                // First qualifying sample is stamped 0; the counter then
                // already reads 1 on the next cycle.
                if (ena && w_qual) begin
                    w_push      = 1'b1;
                    w_ts_nxt    = TS_W'(1);
                    w_state_nxt = ST_CAPTURE;
                end
                if (stop) w_state_nxt = ST_DONE;
            end
            ST_CAPTURE: begin
                if (ena) begin
                    w_push   = w_qual;
                    w_ts_nxt = r_ts + TS_W'(1);
                end
                if (stop) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (arm) begin
                    w_state_nxt = ST_ARMED;
                    w_ts_nxt    = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    capture_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W + DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_data     ({r_ts, r_cur}),
        .i_pop      (rd_ready),
        .i_clear    (clear),
        .o_valid    (rd_valid),
        .o_data     (rd_data),
        .o_count    (count),
        .o_full     (full),
        .o_overflow (overflow)
    );

    assign state = r_state;

endmodule
